fir_decimator: RTL and testbench
================================

Name: fir_decimator

Overview:
Integrate-and-dump decimator directly downstream of the 8-tap transposed-form FIR; consumes one FIR output sample per clock.
- Sums DEC consecutive valid samples and emits one decimated result per window.
- Results pass through a 2-entry output buffer with a valid/ready handshake to the next consumer.
- FIR runs free, so the input side has no backpressure; overrun is flagged, not stalled.

Parameters:
IN_W, 4, width of FIR output sample (unsigned; 8 binary taps give a maximum sum of 8).
DEC, 4, decimation ratio: number of input samples per output (>= 2).
OUT_W, 6, accumulator and output width; must be >= IN_W + clog2(DEC).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  in_data carries a valid FIR sample this cycle.
in_data  input  IN_W  FIR output sample, unsigned.
out_valid  output  1  out_data holds a valid decimated result.
out_ready  input  1  consumer accepts out_data this cycle.
out_data  output  OUT_W  decimated sum, unsigned.
drop  output  1  sticky: at least one result was lost because the buffer was full.

Behaviour:
Interface decision: one clock, clk. Reset rst is asynchronous and active-high.

Reset:
- acc=0, cnt=0, buffer empty.
- out_valid=0, out_data=0, drop=0.
- Reset asserted mid-window discards the partial sum and any buffered results.

Accumulate:
- On a rising edge with in_valid=1 and cnt<DEC-1: acc <= acc + in_data; cnt <= cnt+1.
- in_valid=0: acc and cnt hold. Gaps do not reset the window.

Dump:
- On a rising edge with in_valid=1 and cnt==DEC-1: result = acc + in_data is pushed to the buffer.
- Same edge: acc <= 0, cnt <= 0. The next valid sample starts a fresh window.

Arithmetic:
- Unsigned, zero-extended to OUT_W.
- With a legal OUT_W no overflow is possible.
- Elaboration-time check fails if OUT_W < IN_W + clog2(DEC).

Latency:
- A result pushed at edge k appears on out_data with out_valid=1 after edge k, if the buffer was empty.
- Otherwise it appears behind the older entry.

Buffer (2 entries, FIFO order):
- Pop on an edge where out_valid=1 and out_ready=1.
- out_data and out_valid stay stable while out_valid=1 and out_ready=0.
- Empty + push: 1 entry.
- 1 entry + push + pop: stays at 1 entry; out_data shows the new result next cycle.
- Full + push + pop on the same edge: push succeeds, count stays 2.
- Full + push without pop: result discarded, drop <= 1. cnt and acc still restart.
- drop clears only on rst.
- out_ready while empty: no effect.

Decomposition:
Shared package fir_pkg:
- IN_W and DEC default constants, shared with the FIR top.
- clog2 constant function.

Sub-module dec_fifo2:
- 2-entry synchronous FIFO: push/data_in, pop, full, empty, data_out.
- Asynchronous active-high reset.
- fir_decimator holds the counter, the accumulator and the drop logic.

Test Plan:
1. DEC=4, out_ready=1, in_valid=1 with samples 1,2,3,4 -> one result of 10, out_valid high exactly one cycle after the 4th edge; next window 0,0,0,1 -> 1.
2. Samples 1,_,2,_,3,4 with in_valid low on the _ cycles -> single result of 10; gaps do not advance cnt.
3. out_ready=0, three full windows of 15,15,15,15 -> results 60 and 60 buffered, third dropped, drop=1; then out_ready=1 -> exactly two 60s popped, out_valid falls, drop stays 1.
4. Buffer full, out_ready=1 on the dump edge of a window summing 7 -> pop and push on the same edge, no drop, popped order is old, old, 7.
5. rst pulsed asynchronously (between edges) after 2 samples of 5 -> outputs zero immediately; next samples 1,1,1,1 -> 4, not 14.
6. out_ready=0 with out_valid=1 for 5 cycles while inputs keep arriving -> out_data constant; all pushes accepted until the buffer is full.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants for the FIR chain and a constant-foldable ceil(log2) helper.
package fir_pkg;

    localparam int IN_W_DEF  = 4;
    localparam int DEC_DEF   = 4;
    localparam int OUT_W_DEF = 6;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_decimator_if.sv
// Sample input, decimated valid/ready output and the sticky overrun flag of the decimator.
interface fir_decimator_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 6
);
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             drop;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, drop
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, drop
    );
endinterface

// File: rtl/fir_decimator_dec_fifo2.sv
// Two-entry FIFO, head always in e0; result visible the cycle after push into an empty buffer.
// Push while full is ignored unless a pop happens on the same edge.
module dec_fifo2 #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] data_in,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] data_out
);
    logic [W-1:0] e0, e1;
    logic [1:0]   count;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign data_out = e0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0    <= '0;
            e1    <= '0;
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        e0    <= data_in;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        e0 <= data_in;
                    end else if (push) begin
                        e1    <= data_in;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                2'd2: begin
                    // Pop shifts the tail to the head; a simultaneous push refills the tail.
                    if (pop) begin
                        e0 <= e1;
                        if (push) e1 <= data_in;
                        else      count <= 2'd1;
                    end
                end
                default: count <= 2'd0;
            endcase
        end
    end
endmodule

// File: rtl/fir_decimator.sv
// Integrate-and-dump decimator: sums DEC valid samples, emits the sum through a 2-entry buffer.
// Input side never stalls; a result arriving at a full, non-draining buffer is lost and sets drop.
module fir_decimator
    import fir_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int DEC   = DEC_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    fir_decimator_if.slave io
);
    localparam int CNT_W = clog2(DEC);

    if (OUT_W < IN_W + clog2(DEC)) begin : g_width_check
        $error("fir_decimator: OUT_W too narrow for IN_W and DEC");
    end

    logic [CNT_W-1:0] cnt;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] sum;
    logic             dump;
    logic             pop;
    logic             full;
    logic             empty;
    logic             push;
    logic             drop_q;

    assign sum  = acc + OUT_W'(io.in_data);
    assign dump = io.in_valid && (cnt == CNT_W'(DEC - 1));
    assign pop  = !empty && io.out_ready;
    assign push = dump && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            drop_q <= 1'b0;
        end else begin
            if (dump) begin
                acc <= '0;
                cnt <= '0;
            end else if (io.in_valid) begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end
            // Window restarts even when its result cannot be stored.
            if (dump && full && !pop) drop_q <= 1'b1;
        end
    end

    dec_fifo2 #(.W(OUT_W)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .data_in  (sum),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .data_out (io.out_data)
    );

    assign io.out_valid = !empty;
    assign io.drop      = drop_q;
endmodule

// File: tb/tb_fir_decimator.sv
// Directed plan followed by random traffic, checked each cycle against a queue-based model.
module tb_fir_decimator;
    localparam int IN_W  = 4;
    localparam int DEC   = 4;
    localparam int OUT_W = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_decimator_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    fir_decimator #(.IN_W(IN_W), .DEC(DEC), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    int errors = 0;
    int checks = 0;

    int win[$];
    int exp_q[$];
    bit m_drop = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        win.delete();
        exp_q.delete();
        m_drop = 1'b0;
    endtask

    // One clock: drive, let the edge happen, advance the model, then compare.
    task automatic step(input logic v, input logic [IN_W-1:0] d, input logic r);
        int  s;
        bit  dmp;
        bit  pp;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        @(posedge clk);
        pp  = r && (exp_q.size() > 0);
        dmp = 1'b0;
        s   = 0;
        if (v) begin
            win.push_back(int'(d));
            if (win.size() == DEC) begin
                foreach (win[i]) s += win[i];
                win.delete();
                dmp = 1'b1;
            end
        end
        if (pp) void'(exp_q.pop_front());
        if (dmp) begin
            if (exp_q.size() < 2) exp_q.push_back(s);
            else                  m_drop = 1'b1;
        end
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) chk("out_data", 32'(bus.out_data), 32'(exp_q[0]));
        chk("drop", 32'(bus.drop), 32'(m_drop));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_drop",      32'(bus.drop),      32'd0);
        #4 rst = 1'b0;
        model_reset();

        // 1: basic window and next window
        step(1, 1, 1); step(1, 2, 1); step(1, 3, 1);
        chk("t1_not_yet", 32'(bus.out_valid), 32'd0);
        step(1, 4, 1);
        chk("t1_sum", 32'(bus.out_data), 32'd10);
        step(1, 0, 1); step(1, 0, 1); step(1, 0, 1); step(1, 1, 1);
        chk("t1_sum2", 32'(bus.out_data), 32'd1);
        step(0, 0, 1);

        // 2: gaps hold the window
        step(1, 1, 1); step(0, 9, 1); step(1, 2, 1); step(0, 9, 1); step(1, 3, 1);
        chk("t2_gap_no_out", 32'(bus.out_valid), 32'd0);
        step(1, 4, 1);
        chk("t2_sum", 32'(bus.out_data), 32'd10);
        step(0, 0, 1);

        // 4: full buffer, pop and push on the same edge
        for (int i = 0; i < 4; i++) step(1, 5, 0);
        step(1, 8, 0); step(1, 8, 0); step(1, 8, 0); step(1, 6, 0);
        step(1, 1, 0); step(1, 2, 0); step(1, 3, 0); step(1, 1, 1);
        chk("t4_head", 32'(bus.out_data), 32'd30);
        chk("t4_no_drop", 32'(bus.drop), 32'd0);
        step(0, 0, 1);
        chk("t4_tail", 32'(bus.out_data), 32'd7);
        step(0, 0, 1);
        chk("t4_empty", 32'(bus.out_valid), 32'd0);

        // 6: held output stays stable while pushes fill the buffer
        for (int i = 0; i < 3; i++) step(1, 3, 1);
        step(1, 3, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 2, 0);
            chk("t6_hold", 32'(bus.out_data), 32'd12);
        end
        step(0, 0, 1);
        chk("t6_second", 32'(bus.out_data), 32'd8);
        step(0, 0, 1);

        // 3: overrun drops the third result
        for (int i = 0; i < 12; i++) step(1, 15, 0);
        chk("t3_drop", 32'(bus.drop), 32'd1);
        step(0, 0, 1);
        chk("t3_second60", 32'(bus.out_data), 32'd60);
        step(0, 0, 1);
        chk("t3_drained", 32'(bus.out_valid), 32'd0);
        chk("t3_drop_sticky", 32'(bus.drop), 32'd1);

        // 5: asynchronous reset mid-window
        for (int i = 0; i < 4; i++) step(1, 1, 0);
        step(1, 5, 0); step(1, 5, 0);
        #2 rst = 1'b1;
        #1;
        chk("t5_valid_cleared", 32'(bus.out_valid), 32'd0);
        chk("t5_data_cleared",  32'(bus.out_data),  32'd0);
        chk("t5_drop_cleared",  32'(bus.drop),      32'd0);
        model_reset();
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1, 1, 1);
        chk("t5_fresh_sum", 32'(bus.out_data), 32'd4);
        step(0, 0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(logic'($urandom_range(0, 9) < 7),
                 IN_W'($urandom_range(0, 8)),
                 logic'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
